instruction_controller: RTL and testbench

//  Control FSM and instruction decoder that drives the datapath control inputs for one instruction at a time.

---
 rtl/instruction_controller.sv | 206 ++++++++++++++++++++
 tb/tb_instruction_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_controller.sv
// instruction_controller
//   Control FSM and decoder for a small 16-bit datapath. A 16-bit instruction
//   is latched into IR when s is seen in WAIT. The datapath is then stepped
//   through Moore states that drive register selects, operand muxes,
//   shift/ALU op, load enables and the register-file write strobe.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-high; forces WAIT and clears IR
//   s         start request, sampled only in WAIT
//   instr     instruction captured into IR on start
//   w         1 while idle in WAIT
//   readnum   register read select
//   writenum  register write select
//   vsel      writeback source (0 = ALU result C, 1 = sximm8)
//   loada     load A register
//   loadb     load B register
//   asel      1 forces the ALU A operand to zero
//   bsel      1 selects sximm5 as B operand (never used by this ISA)
//   shift     shifter op, taken from IR[4:3]
//   ALUop     ALU op
//   loadc     load C register
//   loads     load status register
//   write     register-file write strobe
//   sximm5    sign-extended IR[4:0]
//   sximm8    sign-extended IR[7:0]
module instruction_controller #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [15:0]      instr,
    output logic             w,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic             vsel,
    output logic             loada,
    output logic             loadb,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       shift,
    output logic [1:0]       ALUop,
    output logic             loadc,
    output logic             loads,
    output logic             write,
    output logic [WIDTH-1:0] sximm5,
    output logic [WIDTH-1:0] sximm8
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_REG,
        S_WRITE_IMM
    } state_t;

    typedef enum logic [2:0] {
        K_MOV_IMM,
        K_MOV_REG,
        K_ADD,
        K_CMP,
        K_AND,
        K_MVN,
        K_ILLEGAL
    } kind_t;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       vsel;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       loadc;
        logic       loads;
        logic       write;
    } ctrl_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] ir;
    logic [15:0] next_ir;
    ctrl_t       ctrl;

    function automatic kind_t classify(input logic [15:0] word);
        kind_t k;
        case ({word[15:13], word[12:11]})
            5'b110_10: k = K_MOV_IMM;
            5'b110_00: k = K_MOV_REG;
            5'b101_00: k = K_ADD;
            5'b101_01: k = K_CMP;
            5'b101_10: k = K_AND;
            5'b101_11: k = K_MVN;
            default:   k = K_ILLEGAL;
        endcase
        return k;
    endfunction

    // Moore output decode for a given state and IR contents.
    function automatic ctrl_t moore_outputs(input state_t st, input logic [15:0] word);
        ctrl_t c;
        kind_t k;
        c = '0;
        k = classify(word);
        case (st)
            S_WAIT: c.w = 1'b1;
            S_GET_A: begin
                c.readnum = word[10:8];
                c.loada   = 1'b1;
            end
            S_GET_B: begin
                c.readnum = word[2:0];
                c.loadb   = 1'b1;
            end
            S_EXEC: begin
                c.shift = word[4:3];
                if (k == K_MOV_REG) begin
                    c.asel  = 1'b1;
                    c.aluop = 2'b00;
                end else begin
                    c.aluop = word[12:11];
                end
                if (k == K_CMP) c.loads = 1'b1;
                else            c.loadc = 1'b1;
            end
            S_WRITE_REG: begin
                c.writenum = word[7:5];
                c.write    = 1'b1;
            end
            S_WRITE_IMM: begin
                c.writenum = word[10:8];
                c.vsel     = 1'b1;
                c.write    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        next_state = state;
        next_ir    = ir;
        case (state)
            S_WAIT: begin
                if (s) begin
                    next_ir    = instr;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                case (classify(ir))
                    K_MOV_IMM:             next_state = S_WRITE_IMM;
                    K_MOV_REG, K_MVN:      next_state = S_GET_B;
                    K_ADD, K_CMP, K_AND:   next_state = S_GET_A;
                    default:               next_state = S_WAIT;
                endcase
            end
            S_GET_A:     next_state = S_GET_B;
            S_GET_B:     next_state = S_EXEC;
            S_EXEC:      next_state = (classify(ir) == K_CMP) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: next_state = S_WAIT;
            S_WRITE_IMM: next_state = S_WAIT;
            default:     next_state = S_WAIT;
        endcase
    end

    // Outputs are registered from the decode of the *next* state and IR, so
    // they line up with the state register while staying glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
            ir    <= '0;
            ctrl  <= moore_outputs(S_WAIT, 16'h0000);
        end else begin
            state <= next_state;
            ir    <= next_ir;
            ctrl  <= moore_outputs(next_state, next_ir);
        end
    end

    assign w        = ctrl.w;
    assign readnum  = ctrl.readnum;
    assign writenum = ctrl.writenum;
    assign vsel     = ctrl.vsel;
    assign loada    = ctrl.loada;
    assign loadb    = ctrl.loadb;
    assign asel     = ctrl.asel;
    assign bsel     = ctrl.bsel;
    assign shift    = ctrl.shift;
    assign ALUop    = ctrl.aluop;
    assign loadc    = ctrl.loadc;
    assign loads    = ctrl.loads;
    assign write    = ctrl.write;

    assign sximm5 = {{(WIDTH-5){ir[4]}}, ir[4:0]};
    assign sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_instruction_controller.sv
// tb_instruction_controller
//   Scoreboard bench for instruction_controller. The driver applies one input
//   vector per clock and pushes the expected output vector produced by a
//   per-instruction action list; a monitor pops and compares on each falling
//   edge.
module tb_instruction_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic [15:0] instr;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic        write;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    always #5 clk = ~clk;

    instruction_controller #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .instr    (instr),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .loadc    (loadc),
        .loads    (loads),
        .write    (write),
        .sximm5   (sximm5),
        .sximm8   (sximm8)
    );

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        vsel;
        logic        loada;
        logic        loadb;
        logic        asel;
        logic        bsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic        loadc;
        logic        loads;
        logic        write;
        logic [15:0] sximm5;
        logic [15:0] sximm8;
    } obs_t;

    obs_t        exp_q[$];
    obs_t        plan[$];
    logic [15:0] m_ir = 16'h0000;
    int unsigned n_vec = 0;
    int unsigned n_miss = 0;
    int unsigned cyc = 0;

    // Cycle with nothing asserted, immediates taken from the given IR.
    function automatic obs_t blank(input logic [15:0] ir);
        obs_t o;
        logic signed [15:0] t5;
        logic signed [15:0] t8;
        t5 = $signed(ir[4:0]);
        t8 = $signed(ir[7:0]);
        o = '0;
        o.sximm5 = t5;
        o.sximm8 = t8;
        return o;
    endfunction

    function automatic obs_t idle(input logic [15:0] ir);
        obs_t o;
        o = blank(ir);
        o.w = 1'b1;
        return o;
    endfunction

    // Expected cycle-by-cycle outputs from the edge that samples s up to
    // and including the cycle where w is 1 again.
    function automatic void build_plan(input logic [15:0] ir);
        obs_t o;
        logic [2:0] opc;
        logic [1:0] op;
        bit mov_imm, mov_reg, alu, is_cmp;
        opc = ir[15:13];
        op  = ir[12:11];
        mov_imm = (opc == 3'b110) && (op == 2'b10);
        mov_reg = (opc == 3'b110) && (op == 2'b00);
        alu     = (opc == 3'b101);
        is_cmp  = alu && (op == 2'b01);
        plan.delete();
        plan.push_back(blank(ir));
        if (mov_imm) begin
            o = blank(ir); o.writenum = ir[10:8]; o.vsel = 1'b1; o.write = 1'b1;
            plan.push_back(o);
        end else if (mov_reg || alu) begin
            if (alu && op != 2'b11) begin
                o = blank(ir); o.readnum = ir[10:8]; o.loada = 1'b1;
                plan.push_back(o);
            end
            o = blank(ir); o.readnum = ir[2:0]; o.loadb = 1'b1;
            plan.push_back(o);
            o = blank(ir);
            o.shift = ir[4:3];
            o.asel  = mov_reg;
            o.aluop = mov_reg ? 2'b00 : op;
            o.loads = is_cmp;
            o.loadc = !is_cmp;
            plan.push_back(o);
            if (!is_cmp) begin
                o = blank(ir); o.writenum = ir[7:5]; o.write = 1'b1;
                plan.push_back(o);
            end
        end
        plan.push_back(idle(ir));
    endfunction

    task automatic cycle(input logic r, input logic sv, input logic [15:0] iv);
        obs_t e;
        reset = r;
        s     = sv;
        instr = iv;
        @(posedge clk);
        if (r) begin
            plan.delete();
            m_ir = 16'h0000;
            e = idle(16'h0000);
        end else if (plan.size() > 0) begin
            e = plan.pop_front();
        end else if (sv) begin
            m_ir = iv;
            build_plan(iv);
            e = plan.pop_front();
        end else begin
            e = idle(m_ir);
        end
        exp_q.push_back(e);
        #1;
    endtask

    task automatic run_instr(input logic [15:0] iv, input int unsigned idle_cycles);
        cycle(1'b0, 1'b1, iv);
        for (int unsigned i = 0; i < idle_cycles; i++)
            cycle(1'b0, 1'b0, 16'($urandom));
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] v;
        int unsigned pick;
        v = 16'($urandom);
        pick = $urandom_range(0, 9);
        if (pick < 3)      v[15:13] = 3'b110;
        else if (pick < 8) v[15:13] = 3'b101;
        return v;
    endfunction

    // Monitor / scoreboard
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {w, readnum, writenum, vsel, loada, loadb, asel, bsel,
                     shift, ALUop, loadc, loads, write, sximm5, sximm8};
                n_vec++;
                if (a !== e)begin
                    n_miss++;
                    $display("FAIL ctrl cycle %0d: got %h required %h (w %b/%b write %b/%b sximm8 %h/%h)",
                             cyc, a, e, a.w, e.w, a.write, e.write, a.sximm8, e.sximm8);
                end
            end
        end
    end

    initial begin
        int unsigned budget;
        reset = 1'b1;
        s     = 1'b0;
        instr = 16'h0000;

        // Reset for two cycles, then idle
        cycle(1'b1, 1'b0, 16'hFFFF);
        cycle(1'b1, 1'b0, 16'hFFFF);
        cycle(1'b0, 1'b0, 16'h1234);

        // Directed instructions
        run_instr(16'hD0FD, 4);   // MOV R0,#-3
        run_instr(16'hA148, 6);   // ADD R2,R1,R0,LSL
        run_instr(16'hA900, 5);   // CMP R1,R0
        run_instr(16'hC075, 5);   // MOV R3,R5,LSR
        run_instr(16'hB8E3, 5);   // MVN R7,R3
        run_instr(16'hB04A, 6);   // AND R2,R0,R2,LSL

        // Reset during GET_B of ADD
        cycle(1'b0, 1'b1, 16'hA148);
        cycle(1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 16'h0000);
        for (int unsigned i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0000);

        // s toggled while busy must not disturb IR
        cycle(1'b0, 1'b1, 16'hA148);
        cycle(1'b0, 1'b1, 16'hD7FF);
        cycle(1'b0, 1'b0, 16'hD7FF);
        cycle(1'b0, 1'b1, 16'hC0E1);
        for (int unsigned i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'hFFFF);

        // Illegal instruction
        run_instr(16'h0000, 4);
        run_instr(16'hE7FF, 3);

        // s held high across several instructions
        for (int unsigned i = 0; i < 16; i++) cycle(1'b0, 1'b1, (i < 8) ? 16'hC075 : 16'hD3F0);
        cycle(1'b0, 1'b0, 16'h0000);
        for (int unsigned i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'h0000);

        // Reset and s together: reset wins
        cycle(1'b1, 1'b1, 16'hD0FD);
        cycle(1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000);

        // Randomized traffic
        for (int unsigned i = 0; i < 2500; i++)
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), rand_instr());
        cycle(1'b0, 1'b0, 16'h0000);

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
